fetch_queue: RTL
================

# fetch_queue

Instruction fetch front end for the pipelined RISC-V core. It sits between the instruction memory and the decode stage. It owns the fetch PC, issues one word-aligned fetch per cycle, and buffers fetched {pc, instruction} pairs in a small FIFO. Decode stalls therefore never stop the PC mid-fetch, and a branch/jump redirect from execute flushes all wrong-path words in one cycle.

## Interface
- `DEPTH`, 4, number of queue entries; power of two, ≥2.
- `RESET_PC`, 32'h0000_0000, fetch PC loaded by reset.
- `NOP`, 32'h0000_0013, instruction word driven on `id_instr_o` when no entry is valid (`addi x0,x0,0`).

Ports:
- `clk`  in  1  core clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `imem_addr_o`  out  32  fetch address; equals `pc_q`.
- `imem_rd_i`  in  32  instruction word at `imem_addr_o`; valid in the same cycle (combinational memory).
- `redirect_i`  in  1  branch/jump taken in execute; flush and reload PC.
- `redirect_pc_i`  in  32  target PC; bits [1:0] are ignored (forced to 0).
- `id_valid_o`  out  1  head entry valid for decode.
- `id_instr_o`  out  32  head instruction, or `NOP` when `id_valid_o`=0.
- `id_pc_o`  out  32  head PC, or 0 when invalid.
- `id_pcplus4_o`  out  32  `id_pc_o`+4, or 0 when invalid.
- `id_ready_i`  in  1  decode accepts the head this cycle (0 = stall).
- `count_o`  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- Storage: circular buffer of `DEPTH` {pc, instr} entries. Read/write pointers are $clog2(DEPTH) bits and wrap modulo `DEPTH`. `count` ranges 0..`DEPTH`.
- Fetch enable: `fetch = !redirect_i && count < DEPTH`. Only when `fetch` is 1 is {`pc_q`, `imem_rd_i`} written at the write pointer and `pc_q` advanced by 4.
- Pop: `pop = id_valid_o && id_ready_i && !redirect_i`. This advances the read pointer.
- Full: no push, even if a pop occurs in the same cycle. `pc_q` holds. `count` decrements on a pop.
- Empty: `id_valid_o`=0, with outputs at `NOP`/0/0.
- Simultaneous push and pop with 0<count<`DEPTH`: `count` is unchanged and both pointers advance.
- Redirect:
  - `pc_q` ← {`redirect_pc_i`[31:2], 2'b00}.
  - Pointers and `count` clear to 0.
  - There is no push and no pop that cycle; the current memory word is discarded.
  - The next cycle fetches the target.
- PC arithmetic is 32-bit modulo: 32'hFFFF_FFFC + 4 wraps to 0.
- Reset (any time, including mid-stream or during a redirect) forces:
  - `pc_q`=`RESET_PC` and `count`=0;
  - `id_valid_o`=0, `id_instr_o`=`NOP`, `id_pc_o`=0, `id_pcplus4_o`=0;
  - `count_o`=0, `imem_addr_o`=`RESET_PC`.

## Timing
- Fetch-to-decode latency is 1 cycle without bypass. A word fetched in the cycle ending at edge N is presented on `id_*` after edge N.
- After `rst` falls, the first rising edge captures `RESET_PC`, and `id_valid_o` rises after that edge.
- Redirect penalty: the target is presented 1 cycle after the redirect edge (0 cycles with bypass).
- `id_*` outputs come from registers/the queue head and are glitch-free. The exception is bypass mode, where they are combinational from `imem_rd_i`.
- Steady state with `id_ready_i`=1 is one instruction per cycle.

## Configuration
- `FETCH_QUEUE_BYPASS_EN` defined:
  - When `count`=0 and `!redirect_i`, `id_valid_o`=1 and `id_*` are driven combinationally from {`pc_q`, `imem_rd_i`}.
  - If `id_ready_i`=1 the word is consumed directly: no write, `count` stays 0, and `pc_q` advances.
  - If `id_ready_i`=0 the word is written normally.
- Undefined: there is no combinational path from `imem_rd_i` to `id_*`, and latency is always 1 cycle.

## Test plan
- Reset then run, `id_ready_i`=1, memory word = address: `id_pc_o` = 0, 4, 8, ... on consecutive cycles; `id_pcplus4_o` = `id_pc_o`+4; `count_o` ≤ 1.
- Hold `id_ready_i`=0 for 8 cycles: `count_o` saturates at 4 and `imem_addr_o` freezes at 16. Release: decode receives 0, 4, 8, 12, 16 in order with no gaps or duplicates.
- Redirect to 32'h0000_0103 while 3 entries are queued: next cycle `count_o`=0 and `imem_addr_o`=0x100. Then 0x100 is presented (1 cycle later without bypass) and no stale PC ever appears.
- Redirect with `id_ready_i`=1 in the same cycle: no pop and no push; the head at the time of redirect never reaches decode.
- Redirect to 32'hFFFF_FFF8 and run: PCs are FFFF_FFF8, FFFF_FFFC, 0000_0000.
- Assert `rst` asynchronously mid-stream with 2 entries queued: outputs immediately go to `NOP`/0 and `count_o`=0; after release, fetch restarts at `RESET_PC`. With the bypass macro, first valid is 0 cycles after release.

Source files
------------

// File: rtl/fetch_queue_if.sv
// Fetch front-end bus: imem port, redirect, decode handshake, occupancy.
// master = fetch_queue side, slave = memory/execute/decode side.
interface fetch_queue_if #(
  parameter int DEPTH = 4
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]   imem_addr_o;
  logic [31:0]   imem_rd_i;
  logic          redirect_i;
  logic [31:0]   redirect_pc_i;
  logic          id_valid_o;
  logic [31:0]   id_instr_o;
  logic [31:0]   id_pc_o;
  logic [31:0]   id_pcplus4_o;
  logic          id_ready_i;
  logic [CW-1:0] count_o;

  modport master (
    output imem_addr_o,
    input  imem_rd_i,
    input  redirect_i,
    input  redirect_pc_i,
    output id_valid_o,
    output id_instr_o,
    output id_pc_o,
    output id_pcplus4_o,
    input  id_ready_i,
    output count_o
  );

  modport slave (
    input  imem_addr_o,
    output imem_rd_i,
    output redirect_i,
    output redirect_pc_i,
    input  id_valid_o,
    input  id_instr_o,
    input  id_pc_o,
    input  id_pcplus4_o,
    output id_ready_i,
    input  count_o
  );
endinterface

// File: rtl/fetch_queue.sv
// Fetch PC owner + {pc,instr} FIFO feeding decode; clk/rst plain, rest on bus.
// Optional FETCH_QUEUE_BYPASS_EN: empty queue forwards imem word to decode.
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input logic           clk,
  input logic           rst,
  fetch_queue_if.master bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  entry_t        ent_q [DEPTH];
  entry_t        head;
  logic [31:0]   pc_q;
  logic [AW-1:0] wptr_q;
  logic [AW-1:0] rptr_q;
  logic [CW-1:0] count_q;
  logic          head_v;
  logic          byp;
  logic          fetch;
  logic          pop;
  logic          direct;
  logic          push;
  logic          unused;

  assign unused = ^bus.redirect_pc_i[1:0];
  assign head_v = count_q != '0;

`ifdef FETCH_QUEUE_BYPASS_EN
  assign byp = !rst && !head_v && !bus.redirect_i;
`else
  assign byp = 1'b0;
`endif

  assign fetch  = !bus.redirect_i
               && (count_q < CW'(DEPTH));
  assign pop    = head_v && bus.id_ready_i
               && !bus.redirect_i;
  // forwarded word is consumed without a write
  assign direct = byp && bus.id_ready_i;
  assign push   = fetch && !direct;
  assign head   = ent_q[rptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_PC;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else if (bus.redirect_i) begin
      pc_q    <= {bus.redirect_pc_i[31:2], 2'b00};
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (fetch) pc_q <= pc_q + 32'd4;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop) rptr_q <= rptr_q + 1'b1;
      if (push && !pop)
        count_q <= count_q + 1'b1;
      else if (pop && !push)
        count_q <= count_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      ent_q[wptr_q] <= '{pc: pc_q,
                         instr: bus.imem_rd_i};
  end

  always_comb begin
    bus.id_valid_o = 1'b0;
    bus.id_instr_o = NOP;
    bus.id_pc_o    = '0;
    if (head_v) begin
      bus.id_valid_o = 1'b1;
      bus.id_instr_o = head.instr;
      bus.id_pc_o    = head.pc;
    end else if (byp) begin
      bus.id_valid_o = 1'b1;
      bus.id_instr_o = bus.imem_rd_i;
      bus.id_pc_o    = pc_q;
    end
  end

  assign bus.id_pcplus4_o = bus.id_valid_o
                          ? bus.id_pc_o + 32'd4
                          : '0;
  assign bus.imem_addr_o  = pc_q;
  assign bus.count_o      = count_q;
endmodule
